// File: rtl/umtrx_pkt_pkg.sv
// Shared definitions for the 36-bit packet line format and error packet layout.
package umtrx_pkt_pkg;

    localparam int LINE_W        = 36;
    localparam int SOF_BIT       = 32;
    localparam int EOF_BIT       = 33;
    localparam int ERR_PKT_LINES = 6;

    localparam logic [3:0]  VITA_HDR_TYPE = 4'h1;
    localparam logic [15:0] ERR_PKT_LEN   = 16'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } err_state_e;

    // Pack a 32-bit word with framing flags; occupancy bits stay zero.
    function automatic logic [LINE_W-1:0] make_line(input logic [31:0] data,
                                                    input logic        sof,
                                                    input logic        eof);
        logic [LINE_W-1:0] line;
        line          = '0;
        line[31:0]    = data;
        line[SOF_BIT] = sof;
        line[EOF_BIT] = eof;
        return line;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/umtrx_err_pkt_gen_if.sv
// Error packet output stream: 36-bit line, valid/ready handshake.
interface umtrx_err_pkt_gen_if;
    logic [35:0] err_out_data;
    logic        err_out_valid;
    logic        err_out_ready;

    modport master (output err_out_data, output err_out_valid, input err_out_ready);
    modport slave  (input err_out_data, input err_out_valid, output err_out_ready);
endinterface

// File: rtl/setting_reg.sv
// Setting-bus register: captures data when the strobe hits its address.
module setting_reg #(
    parameter logic [7:0]   MY_ADDR  = 8'd0,
    parameter int           WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // Load a new value on an address match, otherwise hold.
    always_comb begin
        out_d = out_q;
        if (strobe && (addr == MY_ADDR)) begin
            out_d = in;
        end
    end

    // Register state; only reset_n restores the default.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q <= AT_RESET;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: rtl/umtrx_err_event_buf.sv
// One-deep pending event register with saturating drop counter.
module umtrx_err_event_buf
    import umtrx_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        evt_stb,
    input  logic [31:0] evt_code,
    input  logic [15:0] evt_seq,
    input  logic [63:0] vita_time,
    input  logic        unload,
    output logic        pend_valid,
    output logic [31:0] pend_code,
    output logic [15:0] pend_seq,
    output logic [63:0] pend_time,
    output logic [15:0] drop_cnt
);
    logic        pend_valid_d, pend_valid_q;
    logic [31:0] pend_code_d, pend_code_q;
    logic [15:0] pend_seq_d, pend_seq_q;
    logic [63:0] pend_time_d, pend_time_q;
    logic [15:0] drop_cnt_d, drop_cnt_q;
    logic        accept;
    logic        drop;
    logic        capture;

    // Capture an event when the slot is free or being emptied this cycle; else count a drop.
    always_comb begin
        accept       = enable && evt_stb;
        drop         = accept && pend_valid_q && !unload;
        capture      = accept && !drop;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        pend_seq_d   = pend_seq_q;
        pend_time_d  = pend_time_q;
        if (unload) begin
            pend_valid_d = 1'b0;
        end
        if (capture) begin
            pend_valid_d = 1'b1;
            pend_code_d  = evt_code;
            pend_seq_d   = evt_seq;
            pend_time_d  = vita_time;
        end
        // The count restarts when the FSM snapshots it; a same-cycle drop still counts.
        drop_cnt_d = unload ? 16'd0 : drop_cnt_q;
        if (drop) begin
            drop_cnt_d = sat_inc16(drop_cnt_d);
        end
    end

    // Control state: cleared by reset_n or clear.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            pend_valid_q <= 1'b0;
            drop_cnt_q   <= 16'd0;
        end else begin
            pend_valid_q <= pend_valid_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Event payload: qualified by pend_valid, so no reset needed.
    always_ff @(posedge clk) begin
        pend_code_q <= pend_code_d;
        pend_seq_q  <= pend_seq_d;
        pend_time_q <= pend_time_d;
    end

    assign pend_valid = pend_valid_q;
    assign pend_code  = pend_code_q;
    assign pend_seq   = pend_seq_q;
    assign pend_time  = pend_time_q;
    assign drop_cnt   = drop_cnt_q;
endmodule

// File: rtl/umtrx_err_pkt_gen.sv
// Converts TX DSP error events into 6-line VITA-style error packets.
module umtrx_err_pkt_gen
    import umtrx_pkt_pkg::*;
#(
    parameter logic [7:0] BASE = 8'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] vita_time,
    input  logic        evt_stb,
    input  logic [31:0] evt_code,
    input  logic [15:0] evt_seq,
    umtrx_err_pkt_gen_if.master err_out,
    output logic [15:0] drop_count
);
    localparam logic [2:0] LAST_IDX = 3'(ERR_PKT_LINES - 1);

    logic        enable;
    logic [31:0] sid;
    logic        pend_valid;
    logic [31:0] pend_code;
    logic [15:0] pend_seq;
    logic [63:0] pend_time;
    logic [15:0] drop_cnt;
    logic        unload;
    logic        out_valid;
    logic [35:0] out_data;

    err_state_e  state_d, state_q;
    logic [2:0]  idx_d, idx_q;
    logic [3:0]  pkt_cnt_d, pkt_cnt_q;
    logic [31:0] sh_code_d, sh_code_q;
    logic [15:0] sh_seq_d, sh_seq_q;
    logic [63:0] sh_time_d, sh_time_q;
    logic [15:0] sh_drop_d, sh_drop_q;

    setting_reg #(.MY_ADDR(BASE), .WIDTH(1), .AT_RESET(1'b0)) u_ctrl_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (set_stb),
        .addr    (set_addr),
        .in      (set_data[0:0]),
        .out     (enable)
    );

    setting_reg #(.MY_ADDR(BASE + 8'd1), .WIDTH(32), .AT_RESET(32'd0)) u_sid_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (set_stb),
        .addr    (set_addr),
        .in      (set_data),
        .out     (sid)
    );

    umtrx_err_event_buf u_event_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .enable     (enable),
        .evt_stb    (evt_stb),
        .evt_code   (evt_code),
        .evt_seq    (evt_seq),
        .vita_time  (vita_time),
        .unload     (unload),
        .pend_valid (pend_valid),
        .pend_code  (pend_code),
        .pend_seq   (pend_seq),
        .pend_time  (pend_time),
        .drop_cnt   (drop_cnt)
    );

    // Packet FSM: IDLE unloads a pending event, EMIT walks the six lines on handshake.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pkt_cnt_d = pkt_cnt_q;
        unload    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_valid) begin
                    unload  = 1'b1;
                    idx_d   = 3'd0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (err_out.err_out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d     = 3'd0;
                        pkt_cnt_d = pkt_cnt_q + 4'd1;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow copy of the event and drop count, frozen for the whole packet.
    always_comb begin
        sh_code_d = sh_code_q;
        sh_seq_d  = sh_seq_q;
        sh_time_d = sh_time_q;
        sh_drop_d = sh_drop_q;
        if (unload) begin
            sh_code_d = pend_code;
            sh_seq_d  = pend_seq;
            sh_time_d = pend_time;
            sh_drop_d = drop_cnt;
        end
    end

    // Line mux: data depends only on registered state, so it holds while stalled.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (idx_q)
                3'd0:    out_data = make_line({VITA_HDR_TYPE, 4'h0, 2'b00, 2'b01,
                                               pkt_cnt_q, ERR_PKT_LEN}, 1'b1, 1'b0);
                3'd1:    out_data = make_line(sid, 1'b0, 1'b0);
                3'd2:    out_data = make_line(sh_time_q[63:32], 1'b0, 1'b0);
                3'd3:    out_data = make_line(sh_time_q[31:0], 1'b0, 1'b0);
                3'd4:    out_data = make_line(sh_code_q, 1'b0, 1'b0);
                default: out_data = make_line({sh_drop_q, sh_seq_q}, 1'b0, 1'b1);
            endcase
        end
    end

    // FSM control registers: reset_n and clear both abandon any packet in flight.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            pkt_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Shadow payload registers: only read while EMIT is active.
    always_ff @(posedge clk) begin
        sh_code_q <= sh_code_d;
        sh_seq_q  <= sh_seq_d;
        sh_time_q <= sh_time_d;
        sh_drop_q <= sh_drop_d;
    end

    assign err_out.err_out_valid = out_valid;
    assign err_out.err_out_data  = out_data;
    assign drop_count            = drop_cnt;
endmodule
